// File: rtl/sram_arb_pkg.sv
// Shared types and sizing helpers for the unified instruction/data SRAM arbiter.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } resp_owner_t;

    localparam int STARVE_MAX_DEF = 4;

    function automatic int starve_w(input int max_cnt);
        return $clog2(max_cnt + 1);
    endfunction

    localparam int STARVE_W = starve_w(STARVE_MAX_DEF);

endpackage

// File: rtl/sram_arb_prio.sv
// Data-first priority decision with a saturating starvation counter that
// forces a fetch grant after STARVE_MAX consecutive fetch losses.
module sram_arb_prio
    import sram_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic inst_req,
    input  logic data_req,
    output logic grant_inst,
    output logic grant_data
);

    localparam int CNT_W = starve_w(STARVE_MAX);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] r_starve_cnt;
    logic             w_inst_forced;

    assign w_inst_forced = (r_starve_cnt == CNT_MAX);

    always_comb begin
        grant_inst = 1'b0;
        grant_data = 1'b0;
        if (!reset) begin
            if (data_req && !(inst_req && w_inst_forced))
                grant_data = 1'b1;
            else if (inst_req)
                grant_inst = 1'b1;
        end
    end

    // Any cycle that is not a fetch loss (fetch won or fetch idle) breaks the streak.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (inst_req && grant_data) begin
            if (r_starve_cnt != CNT_MAX)
                r_starve_cnt <= r_starve_cnt + 1'b1;
        end else begin
            r_starve_cnt <= '0;
        end
    end

endmodule

// File: rtl/unified_sram_arbiter.sv
// Shares one single-port synchronous SRAM between the fetch and load/store
// ports: same-cycle grant, one-cycle data_ok, one access per cycle.
module unified_sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    logic        w_grant_inst;
    logic        w_grant_data;
    resp_owner_t r_resp_owner;

    sram_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .clk        (clk),
        .reset      (reset),
        .inst_req   (inst_req),
        .data_req   (data_req),
        .grant_inst (w_grant_inst),
        .grant_data (w_grant_data)
    );

    assign inst_addr_ok = w_grant_inst;
    assign data_addr_ok = w_grant_data;

    always_comb begin
        sram_en    = w_grant_inst | w_grant_data;
        sram_we    = w_grant_data & data_we;
        sram_addr  = '0;
        sram_wdata = '0;
        if (w_grant_data)
            sram_addr = data_addr;
        else if (w_grant_inst)
            sram_addr = inst_addr;
        if (sram_en)
            sram_wdata = data_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_resp_owner <= OWN_NONE;
        else if (w_grant_inst)
            r_resp_owner <= OWN_INST;
        else if (w_grant_data)
            r_resp_owner <= OWN_DATA;
        else
            r_resp_owner <= OWN_NONE;
    end

    // Read data is shared; each port qualifies it with its own data_ok.
    assign inst_data_ok = (r_resp_owner == OWN_INST);
    assign data_data_ok = (r_resp_owner == OWN_DATA);
    assign inst_rdata   = sram_rdata;
    assign data_rdata   = sram_rdata;

endmodule

// File: tb/tb_unified_sram_arbiter.sv
// Self-checking bench for unified_sram_arbiter: directed scenarios plus a
// randomized run against a rule-level reference model with its own memory.
module tb_unified_sram_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SM = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          inst_req, data_req, data_we;
    logic [AW-1:0] inst_addr, data_addr;
    logic [DW-1:0] data_wdata;
    logic          inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [DW-1:0] inst_rdata, data_rdata;
    logic          sram_en, sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    unified_sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    function automatic logic [31:0] init_word(input int i);
        return 32'h1C00_0000 ^ (32'(i) * 32'h0001_0101);
    endfunction

    // Physical SRAM: synchronous, read data one cycle after the access.
    logic [31:0] sram_mem [0:255];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) sram_mem[i] <= init_word(i);
        end else if (sram_en) begin
            if (sram_we) sram_mem[sram_addr[9:2]] <= sram_wdata;
            else         sram_rdata <= sram_mem[sram_addr[9:2]];
        end
    end

    // Reference model state: fetch-loss streak, last winner, expected read word.
    int          losses = 0;
    int          prev_owner = 0;   // 0 none, 1 inst, 2 data
    logic [31:0] exp_rd = '0;
    logic        exp_rd_vld = 1'b0;
    logic [31:0] ref_mem [0:255];
    logic        mon_gi = 1'b0, mon_gd = 1'b0;

    function automatic int exp_winner();
        if (reset) return 0;
        if (inst_req && data_req) return (losses >= SM) ? 1 : 2;
        if (data_req) return 2;
        if (inst_req) return 1;
        return 0;
    endfunction

    task automatic tick();
        int w;
        w = exp_winner();
        checks++;
        if ((inst_addr_ok && data_addr_ok) || (inst_data_ok && data_data_ok) ||
            (inst_data_ok && !mon_gi) || (data_data_ok && !mon_gd)) begin
            errors++;
            $display("FAIL invariant: addr_ok=%b%b data_ok=%b%b prior_grant=%b%b, need exclusive oks and data_ok only after own grant",
                     inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, mon_gi, mon_gd);
        end
        mon_gi = inst_addr_ok;
        mon_gd = data_addr_ok;
        @(posedge clk);
        if (reset) begin
            losses = 0;
            prev_owner = 0;
            exp_rd_vld = 1'b0;
            for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        end else begin
            if (w == 2 && inst_req) losses = (losses < SM) ? losses + 1 : SM;
            else                    losses = 0;
            prev_owner = w;
            exp_rd_vld = 1'b0;
            if (w == 1) begin
                exp_rd = ref_mem[inst_addr[9:2]]; exp_rd_vld = 1'b1;
            end else if (w == 2 && !data_we) begin
                exp_rd = ref_mem[data_addr[9:2]]; exp_rd_vld = 1'b1;
            end else if (w == 2) begin
                ref_mem[data_addr[9:2]] = data_wdata;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        inst_req = 0; data_req = 0; data_we = 0;
        inst_addr = '0; data_addr = '0; data_wdata = '0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (c == 1) begin
                checks++;
                if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, sram_en} !== 5'b0) begin
                    errors++;
                    $display("FAIL reset_outputs: got %b need 00000",
                             {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, sram_en});
                end
            end
            tick();
        end
        reset = 1'b0;
    endtask

    task automatic test_fetch_only();
        for (int c = 0; c < 5; c++) begin
            inst_req = (c < 3);
            inst_addr = 32'h1c00_0000;
            @(negedge clk);
            checks++;
            if (inst_addr_ok !== (c < 3) || data_addr_ok !== 1'b0 || data_data_ok !== 1'b0 ||
                inst_data_ok !== (c >= 1 && c <= 3) || sram_en !== (c < 3)) begin
                errors++;
                $display("FAIL fetch_hs c=%0d: iaok=%b idok=%b daok=%b ddok=%b en=%b", c,
                         inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, sram_en);
            end
            if (c >= 1 && c <= 3) begin
                checks++;
                if (inst_rdata !== init_word(0)) begin
                    errors++;
                    $display("FAIL fetch_rdata c=%0d: got %h need %h", c, inst_rdata, init_word(0));
                end
            end
            tick();
        end
    endtask

    task automatic test_store_load();
        for (int c = 0; c < 3; c++) begin
            data_req = (c < 2); data_we = (c == 0);
            data_addr = 32'h100; data_wdata = 32'hdeadbeef;
            @(negedge clk);
            checks++;
            if (sram_we !== (c == 0) || data_addr_ok !== (c < 2) || data_data_ok !== (c >= 1) ||
                (c == 0 && sram_wdata !== 32'hdeadbeef)) begin
                errors++;
                $display("FAIL store_load c=%0d: we=%b daok=%b ddok=%b wdata=%h", c,
                         sram_we, data_addr_ok, data_data_ok, sram_wdata);
            end
            if (c == 2) begin
                checks++;
                if (data_rdata !== 32'hdeadbeef) begin
                    errors++;
                    $display("FAIL load_after_store: got %h need deadbeef", data_rdata);
                end
            end
            tick();
        end
        data_we = 0;
    endtask

    task automatic test_contention();
        inst_req = 1; data_req = 1; data_we = 0;
        inst_addr = 32'h40; data_addr = 32'h80;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            checks++;
            if (inst_addr_ok !== (k % 5 == 4) || data_addr_ok !== (k % 5 != 4)) begin
                errors++;
                $display("FAIL contention k=%0d: iaok=%b daok=%b need inst=%0d", k,
                         inst_addr_ok, data_addr_ok, (k % 5 == 4));
            end
            if (k > 0) begin
                checks++;
                if (inst_data_ok !== ((k - 1) % 5 == 4) || data_data_ok !== ((k - 1) % 5 != 4)) begin
                    errors++;
                    $display("FAIL contention_resp k=%0d: idok=%b ddok=%b", k, inst_data_ok, data_data_ok);
                end
            end
            tick();
        end
    endtask

    task automatic test_idle_gaps();
        int w;
        for (int k = 0; k < 10; k++) begin
            inst_req = 0; data_req = 0; data_we = 0;
            if (k % 2 == 0) begin
                if ($urandom_range(0, 1) == 1) begin data_req = 1; data_addr = 32'(k * 4); end
                else                           begin inst_req = 1; inst_addr = 32'(k * 4); end
            end
            @(negedge clk);
            w = exp_winner();
            checks++;
            if (sram_en !== (k % 2 == 0) || inst_addr_ok !== (w == 1) || data_addr_ok !== (w == 2) ||
                inst_data_ok !== (prev_owner == 1) || data_data_ok !== (prev_owner == 2)) begin
                errors++;
                $display("FAIL idle_gaps k=%0d: en=%b aok=%b%b dok=%b%b prev=%0d", k, sram_en,
                         inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, prev_owner);
            end
            if (k > 0 && k % 2 == 0) begin
                checks++;
                if (inst_data_ok || data_data_ok) begin
                    errors++;
                    $display("FAIL idle_gap_resp k=%0d: data_ok=%b%b after idle", k, inst_data_ok, data_data_ok);
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        inst_req = 1; data_req = 1; data_we = 0;
        inst_addr = 32'h10; data_addr = 32'h20;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0) begin
                errors++;
                $display("FAIL pre_reset c=%0d: aok=%b%b need 01", c, inst_addr_ok, data_addr_ok);
            end
            tick();
        end
        reset = 1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (inst_addr_ok || data_addr_ok || sram_en ||
                (c == 1 && ({inst_data_ok, data_data_ok, sram_we} !== 3'b0 ||
                            sram_addr !== '0 || sram_wdata !== '0))) begin
                errors++;
                $display("FAIL reset_mid c=%0d: aok=%b%b dok=%b%b en=%b we=%b addr=%h wd=%h", c,
                         inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok,
                         sram_en, sram_we, sram_addr, sram_wdata);
            end
            tick();
        end
        reset = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (inst_addr_ok !== (k == 4) || data_addr_ok !== (k != 4)) begin
                errors++;
                $display("FAIL post_reset_prio k=%0d: aok=%b%b", k, inst_addr_ok, data_addr_ok);
            end
            tick();
        end
        inst_req = 0; data_req = 0;
        @(negedge clk);
        tick();
    endtask

    task automatic test_random();
        int          w;
        logic [31:0] ea;
        for (int c = 0; c < 400; c++) begin
            if (!inst_req && $urandom_range(0, 3) != 0) begin
                inst_req = 1; inst_addr = 32'($urandom_range(0, 15)) << 2;
            end
            if (!data_req && $urandom_range(0, 3) != 0) begin
                data_req = 1; data_we = 1'($urandom_range(0, 1));
                data_addr = 32'($urandom_range(0, 15)) << 2; data_wdata = $urandom;
            end
            @(negedge clk);
            w = exp_winner();
            ea = (w == 2) ? data_addr : (w == 1) ? inst_addr : 32'h0;
            checks++;
            if (inst_addr_ok !== (w == 1) || data_addr_ok !== (w == 2) || sram_en !== (w != 0) ||
                sram_we !== (w == 2 && data_we) || sram_addr !== ea ||
                sram_wdata !== ((w != 0) ? data_wdata : 32'h0)) begin
                errors++;
                $display("FAIL rand_grant c=%0d: aok=%b%b en=%b we=%b addr=%h need winner=%0d addr=%h",
                         c, inst_addr_ok, data_addr_ok, sram_en, sram_we, sram_addr, w, ea);
            end
            checks++;
            if (inst_data_ok !== (prev_owner == 1) || data_data_ok !== (prev_owner == 2)) begin
                errors++;
                $display("FAIL rand_resp c=%0d: dok=%b%b need owner=%0d", c,
                         inst_data_ok, data_data_ok, prev_owner);
            end
            if (exp_rd_vld) begin
                checks++;
                if ((prev_owner == 1 && inst_rdata !== exp_rd) || (prev_owner == 2 && data_rdata !== exp_rd)) begin
                    errors++;
                    $display("FAIL rand_rdata c=%0d: got %h/%h need %h", c, inst_rdata, data_rdata, exp_rd);
                end
            end
            tick();
            if (w == 1) inst_req = 0;
            if (w == 2) data_req = 0;
        end
        inst_req = 0; data_req = 0;
    endtask

    initial begin
        test_reset();
        test_fetch_only();
        test_store_load();
        test_contention();
        test_idle_gaps();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
